// File: rtl/word_serializer.sv
// word_serializer: parallel-in, serial-out stage with valid/ready word intake,
// per-bit strobe, last-bit marker and an optional idle gap between words.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for a word; o_ready high once out of reset
//   S_SHIFT | emitting captured word, one bit per clock
//   S_GAP   | forced idle cycles after a word's last bit
module word_serializer #(
  parameter int WIDTH      = 8,
  parameter bit LSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_serial,
  output logic             o_bit_valid,
  output logic             o_last,
  output logic             o_busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [7:0]    GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_bit_cnt;
  logic [7:0]       r_gap_cnt;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CW-1:0]    w_bit_cnt_nxt;
  logic [7:0]       w_gap_cnt_nxt;

  logic             w_last_bit;
  logic             w_out_bit;
  logic [WIDTH-1:0] w_shifted;

  // The outgoing bit always sits at the same end of the shift register, so the
  // register moves toward that end each cycle instead of muxing by bit count.
  assign w_last_bit = (r_bit_cnt == LAST_BIT);
  assign w_out_bit  = LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1];
  assign w_shifted  = LSB_FIRST ? {1'b0, r_shift[WIDTH-1:1]}
                                : {r_shift[WIDTH-2:0], 1'b0};

  // State register with asynchronous clear; a word in flight is simply dropped.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

  // Next-state and output decode; o_ready depends only on registered state and
  // reset, never on i_valid.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    o_ready       = 1'b0;
    o_serial      = 1'b0;
    o_bit_valid   = 1'b0;
    o_last        = 1'b0;
    o_busy        = 1'b0;

    case (r_state)
      S_IDLE: begin
        o_ready = i_reset_n;
        if (i_reset_n && i_valid) begin
          w_state_nxt   = S_SHIFT;
          w_shift_nxt   = i_data;
          w_bit_cnt_nxt = '0;
        end
      end

      S_SHIFT: begin
        o_busy      = 1'b1;
        o_bit_valid = 1'b1;
        o_serial    = w_out_bit;
        o_last      = w_last_bit;
        if (w_last_bit) begin
          w_shift_nxt   = '0;
          w_bit_cnt_nxt = '0;
          if (GAP_CYCLES > 0) begin
            w_state_nxt   = S_GAP;
            w_gap_cnt_nxt = GAP_LOAD;
          end else begin
            // With no gap, the last-bit cycle doubles as the intake slot so
            // back-to-back words stream without a bubble.
            o_ready = i_reset_n;
            if (i_reset_n && i_valid) begin
              w_state_nxt = S_SHIFT;
              w_shift_nxt = i_data;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + CW'(1);
          w_shift_nxt   = w_shifted;
        end
      end

      S_GAP: begin
        o_busy = 1'b1;
        if (r_gap_cnt == 8'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 8'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: two instances (LSB-first/no gap, MSB-first/2-cycle
// gap) driven with directed and random words. A timing-level reference model
// predicts acceptance, per-bit cycle, value and last flag for every word.
module tb_word_serializer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [W-1:0] tb_data  [2];
  logic         tb_valid [2];
  logic         o_ready_a     [2];
  logic         o_serial_a    [2];
  logic         o_bit_valid_a [2];
  logic         o_last_a      [2];
  logic         o_busy_a      [2];
  int           pending [2];

  typedef struct {
    int   cyc;
    logic bitv;
    logic last;
  } exp_t;

  always #5 clk = ~clk;

  // Cycle index: the period following the n-th rising edge is cycle n.
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int ch, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s ch%0d cyc=%0d actual=%0d required=%0d", name, ch, cyc, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam bit LSB = (g == 0);
    localparam int GAP = (g == 0) ? 0 : 2;

    exp_t q[$];
    exp_t e;
    int   ready_from = 0;
    int   gap_lo = 1;
    int   gap_hi = 0;
    int   c;
    logic exp_ready;
    logic exp_busy;
    logic [W-1:0] d;

    word_serializer #(
      .WIDTH     (W),
      .LSB_FIRST (LSB),
      .GAP_CYCLES(GAP)
    ) dut (
      .clk        (clk),
      .i_reset_n  (rst_n),
      .i_data     (tb_data[g]),
      .i_valid    (tb_valid[g]),
      .o_ready    (o_ready_a[g]),
      .o_serial   (o_serial_a[g]),
      .o_bit_valid(o_bit_valid_a[g]),
      .o_last     (o_last_a[g]),
      .o_busy     (o_busy_a[g])
    );

    // Reset discards everything the model expected to see.
    always @(negedge rst_n) begin
      q.delete();
      ready_from = 0;
      gap_lo     = 1;
      gap_hi     = 0;
      pending[g] = 0;
    end

    // Monitor and model: compare outputs mid-cycle, then decide acceptance.
    always @(negedge clk) begin
      c = cyc;
      exp_ready = rst_n && (c >= ready_from);
      exp_busy  = rst_n && ((q.size() > 0 && q[0].cyc == c) || (c >= gap_lo && c <= gap_hi));
      chk("ready", g, int'(o_ready_a[g]), int'(exp_ready));
      chk("busy",  g, int'(o_busy_a[g]),  int'(exp_busy));
      if (o_bit_valid_a[g]) begin
        if (q.size() == 0) begin
          chk("unexpected_bit", g, 1, 0);
        end else begin
          e = q.pop_front();
          chk("bit_cycle", g, c, e.cyc);
          chk("serial",    g, int'(o_serial_a[g]), int'(e.bitv));
          chk("last",      g, int'(o_last_a[g]),   int'(e.last));
        end
      end else begin
        chk("idle_serial", g, int'(o_serial_a[g]), 0);
        chk("idle_last",   g, int'(o_last_a[g]),   0);
        while (q.size() > 0 && q[0].cyc <= c) begin
          e = q.pop_front();
          chk("missing_bit", g, 0, 1);
        end
      end
      if (exp_ready && tb_valid[g]) begin
        d = tb_data[g];
        for (int i = 0; i < W; i++) begin
          e.cyc  = c + 1 + i;
          e.bitv = LSB ? d[i] : d[W-1-i];
          e.last = (i == W - 1);
          q.push_back(e);
        end
        gap_lo     = c + W + 1;
        gap_hi     = c + W + GAP;
        ready_from = (GAP == 0) ? c + W : c + W + GAP + 1;
      end
      pending[g] = q.size();
    end
  end

  // Present a word on both channels and hold it until each is accepted.
  task automatic send_both(input logic [W-1:0] dw);
    bit done [2];
    bit rdy  [2];
    int n;
    n = 0;
    for (int k = 0; k < 2; k++) begin
      done[k]     = 1'b0;
      tb_valid[k] = 1'b1;
      tb_data[k]  = dw;
    end
    while (!(done[0] && done[1]) && n < 200) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) rdy[k] = o_ready_a[k] && tb_valid[k];
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (rdy[k]) begin
          done[k]     = 1'b1;
          tb_valid[k] = 1'b0;
          tb_data[k]  = W'($urandom);
        end
      end
      n++;
    end
    for (int k = 0; k < 2; k++) chk("send_timeout", k, int'(done[k]), 1);
  endtask

  // mode 0: idle, mode 1: valid held high, otherwise random valid; data random.
  task automatic run_cycles(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        tb_data[k] = W'($urandom);
        if (mode == 0)      tb_valid[k] = 1'b0;
        else if (mode == 1) tb_valid[k] = 1'b1;
        else                tb_valid[k] = ($urandom_range(0, 2) == 0);
      end
    end
  endtask

  // Assert reset mid-cycle and confirm every output drops at once.
  task automatic reset_mid_cycle();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready",     k, int'(o_ready_a[k]),     0);
      chk("rst_serial",    k, int'(o_serial_a[k]),    0);
      chk("rst_bit_valid", k, int'(o_bit_valid_a[k]), 0);
      chk("rst_last",      k, int'(o_last_a[k]),      0);
      chk("rst_busy",      k, int'(o_busy_a[k]),      0);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      tb_data[k]  = '0;
      tb_valid[k] = 1'b0;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    send_both(8'hA5);
    run_cycles(15, 0);
    send_both(8'h80);
    run_cycles(15, 0);

    send_both(8'h01);
    send_both(8'h80);
    run_cycles(20, 0);

    run_cycles(200, 1);
    run_cycles(20, 0);
    run_cycles(300, 2);
    run_cycles(20, 0);

    reset_mid_cycle();
    run_cycles(3, 0);

    send_both(W'($urandom));
    repeat (3) @(posedge clk);
    #1;
    tb_data[0]  = ~tb_data[0];
    tb_data[1]  = ~tb_data[1];
    tb_valid[0] = 1'b1;
    tb_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    tb_valid[0] = 1'b0;
    tb_valid[1] = 1'b0;
    reset_mid_cycle();
    send_both(8'hC3);
    run_cycles(20, 0);

    run_cycles(200, 2);
    run_cycles(30, 0);

    for (int k = 0; k < 2; k++) chk("drained", k, pending[k], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
